// File: rtl/xgmii_frame_checker.sv
// XGMII Rx frame checker: validates preamble, counting payload pattern, length and termination.
// Define XGMII_CHK_LANE4_START_EN to also accept frames that start in lane 4.
module xgmii_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_156,
    input  logic        rst_156_n,
    input  logic [63:0] xgmii_data,
    input  logic [7:0]  xgmii_ctrl,
    input  logic        xgmii_ena,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_len,
    output logic [31:0] good_cnt,
    output logic [31:0] err_cnt,
    output logic [1:0]  fsm_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2} state_t;

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    state_t      state;
    logic [15:0] run_len;
    logic        run_bad;

    logic        sof0;
    logic        pre0_ok;
    logic [2:0]  first_lane;
    logic        pre_bad;
    logic        term_found;
    logic        scan_bad;
    logic [3:0]  term_pos;
    logic [3:0]  pos;
    logic [7:0]  lane_b;
    logic [16:0] end_sum;
    logic [16:0] run_sum;
    logic [15:0] end_len;
    logic        in_frame;
    logic        end_fire;
    logic        end_bad;
    logic        end_good;

    assign sof0    = xgmii_ctrl[0] && (xgmii_data[7:0] == 8'hFB);
    assign pre0_ok = (xgmii_ctrl[7:1] == 7'd0) && (xgmii_data[63:8] == 56'hD5_5555_5555_5555);

`ifdef XGMII_CHK_LANE4_START_EN
    logic sof4;
    logic pre4_ok;
    assign sof4       = (xgmii_ctrl[4:0] == 5'h1F) && (xgmii_data[39:32] == 8'hFB);
    assign pre4_ok    = (xgmii_ctrl[7:5] == 3'd0) && (xgmii_data[31:0] == 32'h0707_0707) &&
                        (xgmii_data[63:40] == 24'h55_5555);
    // The word after a lane-4 start carries the preamble tail in lanes 0-3.
    assign first_lane = (state == PRE) ? 3'd4 : 3'd0;
    assign pre_bad    = (state == PRE) &&
                        ((xgmii_ctrl[3:0] != 4'd0) || (xgmii_data[31:0] != 32'hD555_5555));
`else
    assign first_lane = 3'd0;
    assign pre_bad    = 1'b0;
`endif

    // Scan payload lanes: pattern check up to the first control lane, idles after it.
    always_comb begin
        term_found = 1'b0;
        scan_bad   = 1'b0;
        term_pos   = 4'd0;
        pos        = 4'd0;
        lane_b     = 8'd0;
        for (int k = 0; k < 8; k++) begin
            lane_b = xgmii_data[8*k +: 8];
            pos    = 4'(k) - {1'b0, first_lane};
            if (4'(k) >= {1'b0, first_lane}) begin
                if (!term_found) begin
                    if (xgmii_ctrl[k]) begin
                        term_found = 1'b1;
                        term_pos   = pos;
                        if (lane_b != 8'hFD) scan_bad = 1'b1;
                    end else if (lane_b != (run_len[7:0] + {4'd0, pos})) begin
                        scan_bad = 1'b1;
                    end
                end else if (!xgmii_ctrl[k] || (lane_b != 8'h07)) begin
                    scan_bad = 1'b1;
                end
            end
        end
    end

    assign end_sum = {1'b0, run_len} + {13'd0, term_pos};
    assign run_sum = {1'b0, run_len} + 17'd8 - {14'd0, first_lane};

    always_comb begin
        in_frame = xgmii_ena && (state != IDLE);
        end_fire = 1'b0;
        end_len  = end_sum[16] ? 16'hFFFF : end_sum[15:0];
        end_bad  = run_bad | scan_bad | pre_bad;
        if (in_frame && (state == DATA) && sof0) begin
            end_fire = 1'b1;
            end_len  = run_len;
            end_bad  = 1'b1;
        end else if (in_frame && term_found) begin
            end_fire = 1'b1;
        end
    end

    assign end_good = !end_bad && (end_len >= MIN_L) && (end_len <= MAX_L);

    always_ff @(posedge clk_156 or negedge rst_156_n) begin
        if (!rst_156_n) begin
            state      <= IDLE;
            run_len    <= 16'd0;
            run_bad    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_len  <= 16'd0;
            good_cnt   <= 32'd0;
            err_cnt    <= 32'd0;
        end else begin
            frame_done <= end_fire;
            if (end_fire) begin
                frame_ok  <= end_good;
                frame_len <= end_len;
                if (end_good) begin
                    if (good_cnt != 32'hFFFF_FFFF) good_cnt <= good_cnt + 32'd1;
                end else if (err_cnt != 32'hFFFF_FFFF) begin
                    err_cnt <= err_cnt + 32'd1;
                end
            end
            if (xgmii_ena) begin
                case (state)
                    IDLE: begin
                        if (sof0) begin
                            state   <= DATA;
                            run_len <= 16'd0;
                            run_bad <= !pre0_ok;
                        end
`ifdef XGMII_CHK_LANE4_START_EN
                        else if (sof4) begin
                            state   <= PRE;
                            run_len <= 16'd0;
                            run_bad <= !pre4_ok;
                        end
`endif
                    end
                    default: begin
                        // A fresh start in DATA closes the old frame and opens a new one at once.
                        if ((state == DATA) && sof0) begin
                            state   <= DATA;
                            run_len <= 16'd0;
                            run_bad <= !pre0_ok;
                        end else if (term_found) begin
                            state   <= IDLE;
                            run_len <= 16'd0;
                            run_bad <= 1'b0;
                        end else begin
                            state   <= DATA;
                            run_len <= run_sum[16] ? 16'hFFFF : run_sum[15:0];
                            run_bad <= end_bad;
                        end
                    end
                endcase
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: doc/xgmii_frame_checker.md
XGMII_FRAME_CHECKER -- requirements
Module: xgmii_frame_checker

Interface
REQ-001 Parameter MIN_LEN, default 64: minimum payload byte count (preamble/SFD excluded, T excluded) for a good frame.
REQ-002 Parameter MAX_LEN, default 1518: maximum payload byte count for a good frame.
REQ-003 clk_156  in  1  XGMII Rx clock; all logic is on its rising edge.
REQ-004 rst_156_n  in  1  asynchronous active-low reset.
REQ-005 xgmii_data  in  64  Rx data; lane k is bits [8k+7:8k].
REQ-006 xgmii_ctrl  in  8  Rx control flags; bit k qualifies lane k.
REQ-007 xgmii_ena  in  1  word valid; a word is consumed only when xgmii_ena=1.
REQ-008 frame_done  out  1  one-cycle pulse at the end of every frame.
REQ-009 frame_ok  out  1  result of the last frame; valid with frame_done and held until the next frame_done.
REQ-010 frame_len  out  16  payload byte count of the last frame; saturates at 0xFFFF.
REQ-011 good_cnt / err_cnt  out  32 each  counts of good and bad frames; saturate at 0xFFFFFFFF.

Function
REQ-012 States: IDLE, PRE, DATA; words with xgmii_ena=0 do not change state, counters or checks.
REQ-013 IDLE: a start word has ctrl[0]=1, lane0=0xFB, ctrl[7:1]=0, lanes1-6=0x55 and lane7=0xD5. A start word goes to DATA with running length 0.
REQ-014 IDLE: a word with ctrl[0]=1 and lane0=0xFB but bad preamble/SFD bytes goes to DATA with the frame marked bad.
REQ-015 DATA: payload byte n of a frame shall equal n mod 256. Byte n in lane k of a word has n = running length + k.
REQ-016 DATA: the first lane with ctrl=1 terminates the frame. If it holds 0xFD, the frame ends cleanly; any other control character ends the frame as bad. All later lanes of that word shall be ctrl=1 with data 0x07 (idle); otherwise the frame is bad.
REQ-017 frame_len = running length + index of the terminating lane; the frame is good only if no error occurred and MIN_LEN <= frame_len <= MAX_LEN.
REQ-018 The running length saturates at 0xFFFF; once it exceeds MAX_LEN, the frame is bad and it continues to be tracked until termination.
REQ-019 A start word (lane0=0xFB with ctrl[0]=1) received in DATA ends the current frame as bad (frame_len = running length) and starts a new frame in the same cycle.
REQ-020 Latency: frame_done, frame_ok, frame_len and the counter update are registered and appear in the cycle after the terminating word is consumed.
REQ-021 A byte-pattern mismatch does not abort the frame; the checker continues to the terminating lane.

Reset
REQ-022 While rst_156_n=0: state=IDLE, running length=0, frame_done=0, frame_ok=0, frame_len=0, good_cnt=0, err_cnt=0.
REQ-023 Reset asserted mid-frame discards the frame with no frame_done and no count change. After release, the checker waits in IDLE for a new start word.

Configuration
REQ-024 Macro XGMII_CHK_LANE4_START_EN: when defined, IDLE also accepts a start in lane 4. The start word has ctrl=0x1F, lanes0-3=0x07, lane4=0xFB and lanes5-7=0x55. The next consumed word goes to PRE and shall carry lanes0-2=0x55 and lane3=0xD5; a mismatch marks the frame bad. Payload byte 0 is in lane 4 of that word, and the FSM goes to DATA.
REQ-025 When the macro is not defined: PRE is not synthesized, and a lane-4 start is treated as idle or noise with no frame counted.

Verification
REQ-026 Lane-0 start, 64 payload bytes 0x00..0x3F, T in lane0 of the next word -> one frame_done, frame_ok=1, frame_len=64, good_cnt=1.
REQ-027 Same frame with byte 17 = 0xFF -> frame_ok=0, frame_len=64, err_cnt=1.
REQ-028 60-byte frame, then a 1519-byte frame -> both frame_ok=0 with frame_len 60 and 1519; err_cnt=2.
REQ-029 64-byte frame with xgmii_ena toggling 1/0 every cycle -> result identical to REQ-026, with frame_done 1 cycle after the T word.
REQ-030 Start word in DATA after 32 bytes, then a good 64-byte frame -> err_cnt=1 (frame_len=32), good_cnt=1; also assert rst_156_n mid-frame -> no frame_done, and all outputs read 0.
REQ-031 With XGMII_CHK_LANE4_START_EN: lane-4 start, 100-byte frame -> frame_ok=1, frame_len=100. Without the macro, the same stimulus gives good_cnt=0 and err_cnt=0.
